regfile_mp: RTL and testbench

Parametrised multi-ported register file for the SPU operand-fetch stage. It serves NUM_RD registered read ports and NUM_WR write ports per cycle. Each read result carries its source address as a tag for downstream forwarding. Clearing is a multi-cycle sweep FSM, not a single-cycle wipe, so large arrays map to RAM-friendly logic.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_clr_fsm.sv | 71 +++++++
 rtl/regfile_mp.sv | 130 +++++++++++++
 tb/tb_regfile_mp.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizing for the multi-ported register file
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W      = 128;
  localparam int RF_DEPTH       = 128;
  localparam int RF_ADDR_W      = $clog2(RF_DEPTH);
  localparam int RF_NUM_RD      = 6;
  localparam int RF_NUM_WR      = 2;
  localparam int RF_CLR_PER_CYC = 8;

  // Tagged read word: data in the upper bits, source address in the lower bits
  typedef struct packed {
    logic [RF_DATA_W-1:0] data;
    logic [RF_ADDR_W-1:0] addr;
  } rd_word_t;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - read/write/control bundle between operand fetch and the register file
interface regfile_mp_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int NUM_RD = 6,
  parameter int NUM_WR = 2
);

  logic                                    clear_req;
  logic [NUM_RD-1:0]                       rd_en;
  logic [NUM_RD-1:0][ADDR_W-1:0]           rd_addr;
  logic [NUM_RD-1:0][DATA_W+ADDR_W-1:0]    rd_data;
  logic [NUM_RD-1:0]                       rd_valid;
  logic [NUM_WR-1:0]                       wr_en;
  logic [NUM_WR-1:0][ADDR_W-1:0]           wr_addr;
  logic [NUM_WR-1:0][DATA_W-1:0]           wr_data;
  logic                                    wr_conflict;
  logic                                    busy;

  modport master (
    output clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, wr_conflict, busy
  );

  modport slave (
    input  clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, wr_conflict, busy
  );

endinterface

// File: rtl/regfile_clr_fsm.sv
// rtl/regfile_clr_fsm.sv - CLEAR/RUN sweep controller producing busy and per-entry clear enables
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int CLR_PER_CYC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_req,
  output logic             busy,
  output logic [DEPTH-1:0] clr_en
);

  localparam int PTR_W = $clog2(DEPTH) + 1;

  rf_state_t        state;
  rf_state_t        state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             last_blk;

  assign last_blk = (ptr == PTR_W'(DEPTH - CLR_PER_CYC));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        if (last_blk) begin
          state_nxt = RUN;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + PTR_W'(CLR_PER_CYC);
        end
      end
      RUN: begin
        if (clear_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Each entry compares its block base against the pointer; a whole block clears together
  always_comb begin
    busy   = (state == CLEAR);
    clr_en = '0;
    if (state == CLEAR) begin
      for (int e = 0; e < DEPTH; e++) begin
        clr_en[e] = (PTR_W'(e - (e % CLR_PER_CYC)) == ptr);
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-ported register file with swept clear; REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int DEPTH       = RF_DEPTH,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int NUM_RD      = RF_NUM_RD,
  parameter int NUM_WR      = RF_NUM_WR,
  parameter int CLR_PER_CYC = RF_CLR_PER_CYC
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  logic                                 busy;
  logic [DEPTH-1:0]                     clr_en;
  logic                                 run_wr;
  logic                                 quiet;
  logic [NUM_WR-1:0]                    wr_ok;
  logic                                 conflict;
  logic [DATA_W-1:0]                    mem [DEPTH];
  logic [NUM_RD-1:0][DATA_W-1:0]        rd_val;
  logic [NUM_RD-1:0][DATA_W+ADDR_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]                    rd_valid_q;
  logic                                 wr_conflict_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  regfile_clr_fsm #(
    .DEPTH       (DEPTH),
    .CLR_PER_CYC (CLR_PER_CYC)
  ) u_clr_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (bus.clear_req),
    .busy      (busy),
    .clr_en    (clr_en)
  );

  assign run_wr = !reset && !busy;
  // A clear_req cycle is treated like CLEAR for outputs so busy and zeroed reads start together
  assign quiet  = reset || busy || bus.clear_req;

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = run_wr && bus.wr_en[j] && in_range(bus.wr_addr[j]);
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (bus.wr_en[j] && bus.wr_en[k] && (bus.wr_addr[j] == bus.wr_addr[k])) begin
          conflict = 1'b1;
        end
      end
    end
  end

  // Per-entry storage: ascending port scan makes the highest-index writer win
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic              we;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] q;

    always_comb begin
      we = 1'b0;
      wd = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (run_wr && bus.wr_en[j] && (bus.wr_addr[j] == ADDR_W'(e))) begin
          we = 1'b1;
          wd = bus.wr_data[j];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (clr_en[e]) begin
        q <= '0;
      end else if (we) begin
        q <= wd;
      end
    end

    assign mem[e] = q;
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_val[i] = '0;
      if (in_range(bus.rd_addr[i])) begin
        rd_val[i] = mem[bus.rd_addr[i]];
      end
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j] && (bus.wr_addr[j] == bus.rd_addr[i])) begin
          rd_val[i] = bus.wr_data[j];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (quiet) begin
      rd_data_q     <= '0;
      rd_valid_q    <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      rd_valid_q    <= bus.rd_en;
      wr_conflict_q <= conflict;
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.rd_en[i]) begin
          rd_data_q[i] <= {rd_val[i], bus.rd_addr[i]};
        end
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and random checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW    = RF_DATA_W;
  localparam int D     = RF_DEPTH;
  localparam int AW    = RF_ADDR_W;
  localparam int NR    = RF_NUM_RD;
  localparam int NW    = RF_NUM_WR;
  localparam int SWEEP = RF_DEPTH / RF_CLR_PER_CYC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_mp #(
    .DATA_W(DW), .DEPTH(D), .NUM_RD(NR), .NUM_WR(NW), .CLR_PER_CYC(RF_CLR_PER_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Model: memory contents, sweep cycles left, expected registered outputs
  logic [DW-1:0] m_mem [D];
  int            m_clr;
  rd_word_t      m_rd [NR];
  logic [NR-1:0] m_vld;
  logic          m_conf;

  int n_asrt = 0;
  int n_fail = 0;

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [DW+AW-1:0] got, input logic [DW+AW-1:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.clear_req = 1'b0;
    bus.rd_en     = '0;
    bus.rd_addr   = '0;
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
  endtask

  task automatic zero_outputs();
    for (int i = 0; i < NR; i++) m_rd[i] = '0;
    m_vld  = '0;
    m_conf = 1'b0;
  endtask

  task automatic model_edge();
    int            hits [int];
    logic [DW-1:0] v;
    if (reset) begin
      m_clr = SWEEP;
      for (int a = 0; a < D; a++) m_mem[a] = '0;
      zero_outputs();
    end else if (m_clr > 0) begin
      m_clr--;
      zero_outputs();
    end else if (bus.clear_req) begin
      m_clr = SWEEP;
      for (int a = 0; a < D; a++) m_mem[a] = '0;
      zero_outputs();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (bus.rd_en[i]) begin
          v = m_mem[bus.rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
          for (int j = 0; j < NW; j++)
            if (bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i]) v = bus.wr_data[j];
`endif
          m_rd[i] = '{data: v, addr: bus.rd_addr[i]};
        end
      end
      m_vld  = bus.rd_en;
      m_conf = 1'b0;
      for (int j = 0; j < NW; j++) begin
        if (bus.wr_en[j]) begin
          if (hits.exists(int'(bus.wr_addr[j]))) m_conf = 1'b1;
          hits[int'(bus.wr_addr[j])] = 1;
        end
      end
      for (int j = 0; j < NW; j++)
        if (bus.wr_en[j]) m_mem[bus.wr_addr[j]] = bus.wr_data[j];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("busy", (DW+AW)'(bus.busy), (DW+AW)'(m_clr > 0));
    chk("wr_conflict", (DW+AW)'(bus.wr_conflict), (DW+AW)'(m_conf));
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("rd_valid[%0d]", i), (DW+AW)'(bus.rd_valid[i]), (DW+AW)'(m_vld[i]));
      chk($sformatf("rd_data[%0d]", i), bus.rd_data[i], m_rd[i]);
    end
  endtask

  task automatic rand_reads();
    for (int i = 0; i < NR; i++) begin
      bus.rd_en[i]   = 1'($urandom_range(0, 1));
      bus.rd_addr[i] = AW'($urandom_range(0, 15));
    end
  endtask

  // mode 1: write during the first busy cycle; mode 2: second clear_req mid-sweep
  task automatic run_sweep(input int mode, output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      idle();
      rand_reads();
      if (mode == 1 && n == 0) begin
        bus.wr_en[0] = 1'b1; bus.wr_addr[0] = AW'(3); bus.wr_data[0] = rand_data();
      end
      if (mode == 2 && n == 5) bus.clear_req = 1'b1;
      n++;
      step();
    end
    idle();
  endtask

  initial begin
    int       n;
    rd_word_t ew;
    logic [DW-1:0] exp4;

    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;

    // Sweep after reset, with a write dropped while busy
    run_sweep(1, n);
    chk("reset_sweep_len", (DW+AW)'(n), (DW+AW)'(SWEEP));
    bus.rd_en[0] = 1'b1; bus.rd_addr[0] = AW'(3);
    step();
    chk("dropped_write", bus.rd_data[0], {{DW{1'b0}}, AW'(3)});

    // Write then read on another port
    idle();
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = AW'(5); bus.wr_data[0] = {16{8'hA5}};
    step();
    idle();
    bus.rd_en[3] = 1'b1; bus.rd_addr[3] = AW'(5);
    step();
    ew = '{data: {16{8'hA5}}, addr: AW'(5)};
    chk("wr_rd_data", bus.rd_data[3], ew);
    chk("wr_rd_valid", (DW+AW)'(bus.rd_valid[3]), (DW+AW)'(1));

    // Write collision
    idle();
    bus.wr_en = '1;
    bus.wr_addr[0] = AW'(9); bus.wr_data[0] = DW'(8'h11);
    bus.wr_addr[1] = AW'(9); bus.wr_data[1] = DW'(8'h22);
    step();
    chk("collision_flag", (DW+AW)'(bus.wr_conflict), (DW+AW)'(1));
    idle();
    bus.rd_en[1] = 1'b1; bus.rd_addr[1] = AW'(9);
    step();
    chk("collision_winner", bus.rd_data[1], {DW'(8'h22), AW'(9)});

    // Same-cycle read and write of one address
    idle();
    bus.wr_en[1] = 1'b1; bus.wr_addr[1] = AW'(12); bus.wr_data[1] = DW'(8'h44);
    step();
    idle();
    bus.wr_en[0] = 1'b1; bus.wr_addr[0] = AW'(12); bus.wr_data[0] = DW'(8'h33);
    bus.rd_en[0] = 1'b1; bus.rd_addr[0] = AW'(12);
    step();
`ifdef REGFILE_BYPASS_EN
    exp4 = DW'(8'h33);
`else
    exp4 = DW'(8'h44);
`endif
    chk("same_cycle_rw", bus.rd_data[0], {exp4, AW'(12)});

    // Fill, clear_req, second clear_req mid-sweep, then read back zeros
    for (int a = 0; a < D; a += 2) begin
      idle();
      bus.wr_en = '1;
      bus.wr_addr[0] = AW'(a);     bus.wr_data[0] = rand_data();
      bus.wr_addr[1] = AW'(a + 1); bus.wr_data[1] = rand_data();
      step();
    end
    idle();
    bus.clear_req = 1'b1;
    step();
    run_sweep(2, n);
    chk("clear_req_sweep_len", (DW+AW)'(n), (DW+AW)'(SWEEP));
    for (int a = 0; a < D; a += NR) begin
      idle();
      for (int i = 0; i < NR; i++) begin
        bus.rd_en[i] = 1'b1; bus.rd_addr[i] = AW'((a + i) % D);
      end
      step();
      chk("cleared_read", bus.rd_data[a % NR], {{DW{1'b0}}, AW'((a + (a % NR)) % D)});
    end

    // Random traffic over a narrow address window to provoke collisions and forwarding
    for (int c = 0; c < 300; c++) begin
      idle();
      rand_reads();
      for (int j = 0; j < NW; j++) begin
        bus.wr_en[j]   = 1'($urandom_range(0, 1));
        bus.wr_addr[j] = AW'($urandom_range(0, 15));
        bus.wr_data[j] = rand_data();
      end
      bus.clear_req = ($urandom_range(0, 39) == 0);
      step();
    end

    // Reset at sweep cycle 10 restarts a full sweep
    run_sweep(0, n);
    idle();
    bus.clear_req = 1'b1;
    step();
    for (int c = 1; c < 10; c++) begin
      idle();
      rand_reads();
      step();
    end
    idle();
    rand_reads();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_sweep(0, n);
    chk("reset_mid_sweep_len", (DW+AW)'(n), (DW+AW)'(SWEEP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
